// File: rtl/rover_i2c_target.sv
// rover_i2c_target: I2C target with a 4 x 8-bit register file and an
// Avalon-MM slave port for the CPU.
//
// I2C side: 7-bit address DEV_ADDR. A write transfer carries a pointer byte,
// then data bytes stored at reg[pointer] with the pointer auto-incrementing.
// A read transfer returns reg[pointer] bytes, and the pointer advances on
// every master ACK. The pointer is 2 bits and wraps 3 -> 0.
//
// Avalon side:
//   address 0..3 : reg[address]
//   address 4    : status {29'b0, done, wr_flag, busy}
//                  writing bit 0 = 1 clears done and wr_flag
//   address 5..7 : read 0, writes ignored
// readdata is registered and follows address every cycle.

module rover_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } state_t;

  // Bus synchronizers and the previous synchronized sample used for edge detection.
  logic scl_meta, scl_s, scl_d;
  logic sda_meta, sda_s, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Protocol state and datapath.
  state_t      state_q, state_d;
  logic [6:0]  shift_q, shift_d;   // seven stored bits; the eighth is sda_s or already on the bus
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        sda_oe_d;
  logic        i2c_we;
  logic [7:0]  i2c_wdata;

  // Register file, status and CPU port.
  logic [7:0]  regs [4];
  logic        done_q, wr_flag_q, busy;
  logic        av_we, status_clr;
  logic        unused_writedata;

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // START/STOP need SCL high on both samples so that an SDA change coinciding
  // with an SCL edge is never mistaken for a bus condition.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign busy       = (state_q != IDLE) && (state_q != IGNORE);
  assign av_we      = chipselect & ~write_n;
  assign status_clr = av_we & (address == 3'd4) & writedata[0];

  // Only the low byte of writedata carries information.
  assign unused_writedata = ^writedata[31:8];

  // Two-flop synchronizers plus one delayed copy for edge and condition detection.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    if (!reset_n) begin
      scl_meta <= 1'b1;
      scl_s    <= 1'b1;
      scl_d    <= 1'b1;
      sda_meta <= 1'b1;
      sda_s    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_meta <= scl_in;
      scl_s    <= scl_meta;
      scl_d    <= scl_s;
      sda_meta <= sda_in;
      sda_s    <= sda_meta;
      sda_d    <= sda_s;
    end
  end

  // Next-state and datapath logic.
  // Bits are sampled on SCL rise, and sda_oe only changes on an SCL fall.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe;
    i2c_we    = 1'b0;
    i2c_wdata = 8'h00;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: sda_oe_d = 1'b0;

        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[5:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (shift_q == DEV_ADDR) begin
                rw_d    = sda_s;
                state_d = ADDR_ACK;
              end else begin
                state_d  = IGNORE;
                sda_oe_d = 1'b0;
              end
            end
          end
        end

        // The fall after the 8th bit pulls SDA low. The fall after the 9th
        // clock ends the ACK, so sda_oe itself marks which half we are in.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else begin
              cnt_d = 4'd0;
              if (rw_q) begin
                state_d  = RDATA;
                shift_d  = regs[ptr_q][6:0];
                sda_oe_d = ~regs[ptr_q][7];
              end else begin
                state_d  = PTR;
                sda_oe_d = 1'b0;
              end
            end
          end
        end

        PTR: begin
          if (scl_rise) begin
            shift_d = {shift_q[5:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              ptr_d   = {shift_q[0], sda_s};
              state_d = PTR_ACK;
            end
          end
        end

        PTR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = WDATA;
            end
          end
        end

        WDATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[5:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              i2c_we    = 1'b1;
              i2c_wdata = {shift_q, sda_s};
              state_d   = WDATA_ACK;
            end
          end
        end

        WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 2'd1;
              cnt_d    = 4'd0;
              state_d  = WDATA;
            end
          end
        end

        // Bit 7 went out on entry. Each later fall presents the next bit
        // until eight bits have been clocked.
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = RDATA_ACK;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[5:0], 1'b0};
            end
          end
        end

        // cnt_q is 8 on entry. A master ACK clears it, and that zero tells
        // the following fall to reload and resume driving.
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = IGNORE;
            end else begin
              ptr_d = ptr_q + 2'd1;
              cnt_d = 4'd0;
            end
          end else if (scl_fall && (cnt_q == 4'd0)) begin
            state_d  = RDATA;
            shift_d  = regs[ptr_q][6:0];
            sda_oe_d = ~regs[ptr_q][7];
          end
        end

        IGNORE: sda_oe_d = 1'b0;

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Protocol state register; reset releases SDA at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= 7'h00;
      cnt_q   <= 4'd0;
      ptr_q   <= 2'd0;
      rw_q    <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      sda_oe  <= sda_oe_d;
    end
  end

  // Register file: CPU writes, then I2C commits.
  // The later assignment wins when both hit the same register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: this small register file has a defined reset value, so it is
    // built from resettable flops rather than a RAM macro.
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else begin
      if (av_we && !address[2]) regs[address[1:0]] <= writedata[7:0];
      if (i2c_we) regs[ptr_q] <= i2c_wdata;
    end
  end

  // Sticky status flags. A same-cycle I2C set overrides a CPU clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      wr_flag_q <= 1'b0;
    end else begin
      if (stop_det)        done_q <= 1'b1;
      else if (status_clr) done_q <= 1'b0;
      if (i2c_we)          wr_flag_q <= 1'b1;
      else if (status_clr) wr_flag_q <= 1'b0;
    end
  end

  // Registered read mux, refreshed every cycle from the current address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'h0;
    end else begin
      case (address)
        3'd0, 3'd1, 3'd2, 3'd3: readdata <= {24'h0, regs[address[1:0]]};
        3'd4:                   readdata <= {29'h0, done_q, wr_flag_q, busy};
        default:                readdata <= 32'h0;
      endcase
    end
  end

endmodule

// File: doc/rover_i2c_target.md
ROVER_I2C_TARGET -- requirements
Module: rover_i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h42, 7-bit I2C target address.
REQ-002 SHALL have clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have scl_in  input  1  I2C SCL pin level, asynchronous to clk.
REQ-005 SHALL have sda_in  input  1  I2C SDA pin level, asynchronous to clk.
REQ-006 SHALL have sda_oe  output  1  1 = drive SDA low (open-drain); 0 = release.
REQ-007 SHALL have address  input  3  Avalon-MM word address.
REQ-008 SHALL have chipselect  input  1  Avalon select.
REQ-009 SHALL have write_n  input  1  Avalon write strobe, active-low.
REQ-010 SHALL have writedata  input  32  Avalon write data; bits [7:0] used.
REQ-011 SHALL have readdata  output  32  Avalon read data, registered, upper bits zero.

Function
REQ-012 SHALL pass scl_in and sda_in through 2-flop synchronizers; all edge detection uses synchronized values only.
REQ-013 SHALL detect START as synchronized SDA 1->0 while SCL=1, and STOP as SDA 0->1 while SCL=1, in any state.
REQ-014 SHALL sample SDA on SCL rising edge and change sda_oe only on the clk cycle after an SCL falling edge.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-016 SHALL enter ADDR on any START (including repeated START), clearing bit counter to 0.
REQ-017 ADDR SHALL shift 8 bits MSB first; on 8th bit, match [7:1]==DEV_ADDR -> ADDR_ACK, else -> IGNORE with sda_oe=0.
REQ-018 ADDR_ACK SHALL assert sda_oe for exactly one SCL high period; after it, R/W=0 -> PTR, R/W=1 -> RDATA.
REQ-019 PTR SHALL receive 8 bits, load pointer with bits [1:0], ACK in PTR_ACK, then go to WDATA.
REQ-020 WDATA SHALL receive 8 bits, write byte to reg[pointer] at end of 8th bit, ACK in WDATA_ACK, increment pointer, return to WDATA.
REQ-021 RDATA SHALL load shift register from reg[pointer] at entry, drive each bit MSB first (sda_oe = ~bit), release SDA in RDATA_ACK.
REQ-022 RDATA_ACK SHALL sample master ACK on SCL rise: 0 -> increment pointer, reload, RDATA; 1 (NACK) -> IGNORE.
REQ-023 Pointer SHALL be 2 bits and wrap 3 -> 0 on increment.
REQ-024 IGNORE SHALL hold sda_oe=0 until next START (-> ADDR) or STOP (-> IDLE).
REQ-025 STOP in any state SHALL go to IDLE, release sda_oe within 1 clk, and set status.done.
REQ-026 Register file SHALL be 4 x 8-bit, reset value 8'h00.
REQ-027 Avalon address 0-3 SHALL read/write reg[address]; address 4 SHALL read status {29'b0, done, wr_flag, busy}; address 5-7 read 0, writes ignored.
REQ-028 busy SHALL be 1 in every state except IDLE and IGNORE; wr_flag SHALL set when an I2C write commits a register byte.
REQ-029 Avalon write to address 4 with writedata[0]=1 SHALL clear done and wr_flag; a same-cycle I2C set takes priority.
REQ-030 readdata SHALL update one clk after the cycle of address, every cycle (no read strobe), like the team's PIO blocks.
REQ-031 On same-cycle Avalon write and I2C commit to the same register, the I2C byte SHALL win.

Reset
REQ-032 reset_n low SHALL asynchronously force: state IDLE, sda_oe=0, readdata=0, pointer=0, regs=0, status=0, synchronizer flops=1.
REQ-033 Reset asserted mid-transfer SHALL release SDA immediately; after release the block ignores the bus until next START.

Verification
REQ-034 Write: START, 0x84, ACK, 0x02, ACK, 0xA5, ACK, 0x3C, ACK, STOP -> reg2=0xA5, reg3=0x3C, status=0x6 read at Avalon address 4.
REQ-035 Read with wrap: CPU writes reg3=0x11, reg0=0x22; START, 0x84, 0x03, repeated START, 0x85, master ACK, NACK -> bytes 0x11 then 0x22 on SDA.
REQ-036 Address mismatch: START, 0x90 -> sda_oe stays 0 through 9th clock; later bytes ignored; regs unchanged.
REQ-037 Clear: Avalon write 0x1 to address 4 after REQ-034 -> status reads 0x0 one cycle later.
REQ-038 Reset mid-byte: drop reset_n while driving data bit 0 in RDATA -> sda_oe=0 same cycle, all regs 0, next START/0x84 acknowledged.
REQ-039 Collision: Avalon write 0x55 to reg1 on same clk as I2C commit 0x99 to reg1 -> reg1 reads 0x99.
